my_irq_controller: RTL and testbench
====================================

# my_irq_controller

Trap sequencer that sits directly upstream of the CSR/privilege block. It latches external interrupt edges, arbitrates interrupts against synchronous exceptions from decode, and issues the one-shot `irq_taken`/`exc_taken`/`irq_done` strobes that the privilege block consumes. It also drives the fetch redirect to the trap vector, computed from `mtvec`, or to the return address, taken from `mepc`.

## Interface
- NUM_IRQ, 16: number of external interrupt lines, 1..32. The interrupt ID equals the line index.
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- fetch_ready_i  in  1  pipeline advance enable; the privilege block commits only when this is high
- irq_lines_i  in  NUM_IRQ  external interrupt lines, level, synchronous to clk_i
- mie_i  in  1  mstatus.MIE from the privilege block
- mtvec_i  in  32  trap vector from the privilege block
- mepc_i  in  32  return PC from the privilege block
- cur_pc_i  in  32  PC of the instruction in decode
- exc_req_i  in  1  synchronous exception request from decode
- exc_id_i  in  5  exception cause: 2 illegal, 3 ebreak, 11 ecall
- mret_i  in  1  decoded MRET
- irq_taken_o  out  1  interrupt trap strobe
- irq_o  out  1  mcause interrupt bit
- irq_id_o  out  5  cause / interrupt ID
- exc_taken_o  out  1  exception trap strobe
- exc_pc_o  out  32  PC to save into mepc
- irq_done_o  out  1  MRET commit strobe
- redirect_o  out  1  fetch redirect valid
- redirect_pc_o  out  32  fetch redirect target
- pending_o  out  NUM_IRQ  pending interrupt vector

## Operation
- FSM states:
  - IDLE: no trap in progress.
  - TRAP: trap strobe and redirect asserted.
  - HANDLER: executing the trap handler.
  - RET: MRET strobe and redirect asserted.
- Pending logic:
  - `pending[i]` sets on a rising edge of `irq_lines_i[i]`, detected against a registered copy of the line.
  - `pending[i]` clears when the trap for ID `i` commits.
  - If a new edge and the clear occur in the same cycle, set wins.
- Arbitration, evaluated in IDLE and HANDLER:
  - `exc_req_i` has the highest priority.
  - Next, if `mie_i`=1 and `pending` is nonzero, the lowest-index pending line is selected.
  - Next, `mret_i`.
- Transitions:
  - IDLE/HANDLER to TRAP on an exception or an enabled interrupt.
  - IDLE/HANDLER to RET on `mret_i`.
  - TRAP to HANDLER when `fetch_ready_i`=1.
  - RET to IDLE when `fetch_ready_i`=1.
- Entering TRAP registers the following:
  - `irq_o`: 1 for an interrupt, 0 for an exception.
  - `irq_id_o`: the line index or `exc_id_i`.
  - `exc_pc_o`: `cur_pc_i`.
  - The redirect target.
- Redirect target:
  - Base is `{mtvec_i[31:2],2'b00}`.
  - For an interrupt with `mtvec_i[1:0]`=01 (vectored), the target is base + 4·ID, computed with 32-bit wrap.
  - Otherwise the target is base.
  - In RET the target is `mepc_i`, sampled live.
- Strobe outputs:
  - `irq_taken_o` = (state==TRAP && `irq_o`).
  - `exc_taken_o` = (state==TRAP && !`irq_o`).
  - `irq_done_o` = (state==RET).
  - `redirect_o` = TRAP or RET.
- Boundary cases:
  - An exception raised inside HANDLER nests: it re-enters TRAP.
  - An interrupt cannot nest, because the privilege block clears MIE on entry.
  - `mret_i` in IDLE is legal and goes to RET.
  - `exc_req_i` together with `mret_i`: the exception wins.
  - `exc_req_i`/`mret_i` arriving while in TRAP or RET are ignored; decode holds them.

## Timing
- Reset values:
  - State is IDLE.
  - All outputs are 0, including `pending_o` and `redirect_pc_o`.
  - The registered line copy is 0.
- Reset is honoured mid-trap: it aborts immediately to IDLE.
- Latency:
  - An edge on `irq_lines_i` at clock N shows in `pending_o` after edge N.
  - If enabled, TRAP is entered after edge N+1.
  - A request sampled at edge N produces strobes from cycle N+1.
- Strobes hold while `fetch_ready_i`=0 and deassert the cycle after the commit edge, so each strobe is accepted exactly once by the privilege block.
- `mie_i` drops the cycle after an interrupt commit, which matches the privilege block's register update.

## Structure
- Add to `my_riscv_defines`:
  - `irq_state_e` (IDLE, TRAP, HANDLER, RET).
  - Cause constants EXC_ILLEGAL=5'd2, EXC_BREAK=5'd3, EXC_ECALL_M=5'd11.
- Sub-module `my_irq_pending`: edge detect, pending register, set/clear priority, and the lowest-index priority encoder. It outputs `any_pending` and `sel_id`.
- The top level contains the FSM, capture registers and redirect adder.

## Test plan
- Line 5 rises, `mie_i`=1, `mtvec_i`=0x0000_1001, `cur_pc_i`=0x200 → `irq_taken_o` for one accepted cycle, `irq_id_o`=5, `irq_o`=1, `exc_pc_o`=0x200, `redirect_pc_o`=0x1014, `pending_o[5]` cleared.
- Lines 3 and 7 rise together, `mie_i`=0 → no trap. Then `mie_i`=1 → ID 3 is taken first; ID 7 is taken after MRET with `mie_i`=1.
- `exc_req_i`=1, `exc_id_i`=11, together with a pending interrupt → `exc_taken_o`, `irq_o`=0, `irq_id_o`=11, `redirect_pc_o`=0x1000.
- `fetch_ready_i`=0 for 3 cycles during TRAP → strobe and redirect are stable for 4 cycles, then drop.
- `mret_i` in HANDLER with `mepc_i`=0x204 → `irq_done_o`=1, `redirect_pc_o`=0x204, return to IDLE.
- `rst_ni` asserted while in TRAP → all outputs are 0 immediately and state is IDLE.

Source files
------------

// File: rtl/my_riscv_defines.sv
// Shared trap-sequencer types, exception cause codes and the trap-vector helper.
package my_riscv_defines;

  typedef enum logic [1:0] {
    IDLE,
    TRAP,
    HANDLER,
    RET
  } irq_state_e;

  localparam logic [4:0] EXC_ILLEGAL = 5'd2;
  localparam logic [4:0] EXC_BREAK   = 5'd3;
  localparam logic [4:0] EXC_ECALL_M = 5'd11;

  // Vectored mode (mtvec[1:0]==01) offsets interrupts only; exceptions always use the base.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic        is_irq,
                                              input logic [4:0]  id);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (is_irq && (mtvec[1:0] == 2'b01)) begin
      return base + {25'b0, id, 2'b00};
    end
    return base;
  endfunction

endpackage

// File: rtl/my_irq_controller_if.sv
// Signal bundle between the trap sequencer and its decode/fetch/privilege neighbours.
interface my_irq_controller_if #(
  parameter int unsigned NUM_IRQ = 16
);

  logic               fetch_ready_i;
  logic [NUM_IRQ-1:0] irq_lines_i;
  logic               mie_i;
  logic [31:0]        mtvec_i;
  logic [31:0]        mepc_i;
  logic [31:0]        cur_pc_i;
  logic               exc_req_i;
  logic [4:0]         exc_id_i;
  logic               mret_i;
  logic               irq_taken_o;
  logic               irq_o;
  logic [4:0]         irq_id_o;
  logic               exc_taken_o;
  logic [31:0]        exc_pc_o;
  logic               irq_done_o;
  logic               redirect_o;
  logic [31:0]        redirect_pc_o;
  logic [NUM_IRQ-1:0] pending_o;

  modport slave (
    input  fetch_ready_i, irq_lines_i, mie_i, mtvec_i, mepc_i, cur_pc_i,
           exc_req_i, exc_id_i, mret_i,
    output irq_taken_o, irq_o, irq_id_o, exc_taken_o, exc_pc_o, irq_done_o,
           redirect_o, redirect_pc_o, pending_o
  );

  modport master (
    output fetch_ready_i, irq_lines_i, mie_i, mtvec_i, mepc_i, cur_pc_i,
           exc_req_i, exc_id_i, mret_i,
    input  irq_taken_o, irq_o, irq_id_o, exc_taken_o, exc_pc_o, irq_done_o,
           redirect_o, redirect_pc_o, pending_o
  );

endinterface

// File: rtl/my_irq_pending.sv
// Interrupt edge capture, pending register with set-over-clear, and lowest-index select.
module my_irq_pending #(
  parameter int unsigned NUM_IRQ = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_IRQ-1:0] irq_lines_i,
  input  logic               clr_en_i,
  input  logic [4:0]         clr_id_i,
  output logic [NUM_IRQ-1:0] pending_o,
  output logic               any_pending_o,
  output logic [4:0]         sel_id_o
);

  logic [NUM_IRQ-1:0] lines_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] clr_mask;

  always_comb begin
    clr_mask = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (clr_en_i && (clr_id_i == 5'(i))) begin
        clr_mask[i] = 1'b1;
      end
    end
    // The edge term is OR'd in last so a fresh edge survives a same-cycle clear.
    pending_d = (pending_q & ~clr_mask) | (irq_lines_i & ~lines_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lines_q   <= '0;
      pending_q <= '0;
    end else begin
      lines_q   <= irq_lines_i;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    sel_id_o = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (pending_q[i-1]) begin
        sel_id_o = 5'(i - 1);
      end
    end
  end

  assign pending_o     = pending_q;
  assign any_pending_o = |pending_q;

endmodule

// File: rtl/my_irq_controller.sv
// Trap sequencer: arbitrates exceptions, interrupts and MRET, and issues one-shot trap strobes and fetch redirects.
module my_irq_controller
  import my_riscv_defines::*;
#(
  parameter int unsigned NUM_IRQ = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  my_irq_controller_if.slave  bus
);

  irq_state_e  state_q, state_d;
  logic        irq_q, irq_d;
  logic [4:0]  id_q, id_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        clr_en;
  logic        any_pending;
  logic [4:0]  sel_id;

  my_irq_pending #(
    .NUM_IRQ(NUM_IRQ)
  ) u_pending (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .irq_lines_i  (bus.irq_lines_i),
    .clr_en_i     (clr_en),
    .clr_id_i     (id_q),
    .pending_o    (bus.pending_o),
    .any_pending_o(any_pending),
    .sel_id_o     (sel_id)
  );

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    id_d    = id_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    clr_en  = 1'b0;
    unique case (state_q)
      IDLE, HANDLER: begin
        if (bus.exc_req_i) begin
          state_d = TRAP;
          irq_d   = 1'b0;
          id_d    = bus.exc_id_i;
          pc_d    = bus.cur_pc_i;
          tgt_d   = trap_target(bus.mtvec_i, 1'b0, bus.exc_id_i);
        end else if (bus.mie_i && any_pending) begin
          state_d = TRAP;
          irq_d   = 1'b1;
          id_d    = sel_id;
          pc_d    = bus.cur_pc_i;
          tgt_d   = trap_target(bus.mtvec_i, 1'b1, sel_id);
        end else if (bus.mret_i) begin
          state_d = RET;
        end
      end
      TRAP: begin
        if (bus.fetch_ready_i) begin
          state_d = HANDLER;
          clr_en  = irq_q;
        end
      end
      RET: begin
        if (bus.fetch_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      id_q    <= '0;
      pc_q    <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  assign bus.irq_taken_o   = (state_q == TRAP) && irq_q;
  assign bus.exc_taken_o   = (state_q == TRAP) && !irq_q;
  assign bus.irq_done_o    = (state_q == RET);
  assign bus.redirect_o    = (state_q == TRAP) || (state_q == RET);
  assign bus.redirect_pc_o = (state_q == RET) ? bus.mepc_i : tgt_q;
  assign bus.irq_o         = irq_q;
  assign bus.irq_id_o      = id_q;
  assign bus.exc_pc_o      = pc_q;

endmodule

// File: tb/tb_my_irq_controller.sv
// Directed and randomized checks of my_irq_controller against a cycle-level behavioural model.
module tb_my_irq_controller;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  my_irq_controller_if #(.NUM_IRQ(16)) bus ();

  my_irq_controller #(
    .NUM_IRQ(16)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Model: mode 0 idle, 1 trap, 2 handler, 3 return
  int          m_mode;
  logic        m_irq;
  logic [4:0]  m_id;
  logic [31:0] m_pc, m_tgt;
  logic [15:0] m_pend, m_prev;
  logic        m_trap_commit, m_ret_commit;

  task automatic model_reset();
    m_mode = 0; m_irq = 1'b0; m_id = '0; m_pc = '0; m_tgt = '0;
    m_pend = '0; m_prev = '0; m_trap_commit = 1'b0; m_ret_commit = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("irq_taken", 32'(bus.irq_taken_o), 32'(m_mode == 1 && m_irq));
    chk("exc_taken", 32'(bus.exc_taken_o), 32'(m_mode == 1 && !m_irq));
    chk("irq_done",  32'(bus.irq_done_o),  32'(m_mode == 3));
    chk("redirect",  32'(bus.redirect_o),  32'(m_mode == 1 || m_mode == 3));
    chk("redir_pc",  bus.redirect_pc_o,    (m_mode == 3) ? bus.mepc_i : m_tgt);
    chk("irq_o",     32'(bus.irq_o),       32'(m_irq));
    chk("irq_id",    32'(bus.irq_id_o),    32'(m_id));
    chk("exc_pc",    bus.exc_pc_o,         m_pc);
    chk("pending",   32'(bus.pending_o),   32'(m_pend));
  endtask

  // Advance one clock: derive next model state from the inputs held across the edge.
  task automatic cycle();
    logic [15:0] np;
    int          nmode, low;
    logic        nirq;
    logic [4:0]  nid;
    logic [31:0] npc, ntgt, base;
    np = m_pend; nmode = m_mode; nirq = m_irq; nid = m_id; npc = m_pc; ntgt = m_tgt;
    m_trap_commit = 1'b0; m_ret_commit = 1'b0;
    low = -1;
    for (int i = 15; i >= 0; i--) if (m_pend[i]) low = i;
    base = bus.mtvec_i & ~32'h3;
    case (m_mode)
      0, 2: begin
        if (bus.exc_req_i) begin
          nmode = 1; nirq = 1'b0; nid = bus.exc_id_i; npc = bus.cur_pc_i; ntgt = base;
        end else if (bus.mie_i && low >= 0) begin
          nmode = 1; nirq = 1'b1; nid = 5'(low); npc = bus.cur_pc_i;
          ntgt = base + ((bus.mtvec_i[1:0] == 2'b01) ? 32'(4 * low) : 32'd0);
        end else if (bus.mret_i) begin
          nmode = 3;
        end
      end
      1: if (bus.fetch_ready_i) begin
        nmode = 2; m_trap_commit = 1'b1;
        if (m_irq) np[m_id[3:0]] = 1'b0;
      end
      default: if (bus.fetch_ready_i) begin
        nmode = 0; m_ret_commit = 1'b1;
      end
    endcase
    np = np | (bus.irq_lines_i & ~m_prev);
    @(posedge clk);
    m_prev = bus.irq_lines_i;
    m_pend = np; m_mode = nmode; m_irq = nirq; m_id = nid; m_pc = npc; m_tgt = ntgt;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.fetch_ready_i = 1'b1;
    bus.irq_lines_i   = '0;
    bus.mie_i         = 1'b0;
    bus.mtvec_i       = 32'h0000_1001;
    bus.mepc_i        = 32'h0000_0204;
    bus.cur_pc_i      = 32'h0000_0200;
    bus.exc_req_i     = 1'b0;
    bus.exc_id_i      = '0;
    bus.mret_i        = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_redir_pc", bus.redirect_pc_o, 32'h0);
    rst_n = 1'b1;

    // Line 5, vectored: 0x1000 + 4*5
    bus.mie_i = 1'b1;
    bus.irq_lines_i[5] = 1'b1;
    cycle();
    chk("t1_pend5", 32'(bus.pending_o[5]), 32'd1);
    chk("t1_no_trap_yet", 32'(bus.irq_taken_o), 32'd0);
    cycle();
    chk("t1_taken", 32'(bus.irq_taken_o), 32'd1);
    chk("t1_id", 32'(bus.irq_id_o), 32'd5);
    chk("t1_tgt", bus.redirect_pc_o, 32'h0000_1014);
    chk("t1_pc", bus.exc_pc_o, 32'h0000_0200);
    cycle();
    chk("t1_taken_drop", 32'(bus.irq_taken_o), 32'd0);
    chk("t1_pend5_clr", 32'(bus.pending_o[5]), 32'd0);
    bus.mie_i = 1'b0;
    bus.irq_lines_i = '0;
    bus.mret_i = 1'b1;
    cycle();
    chk("t1_done", 32'(bus.irq_done_o), 32'd1);
    chk("t1_ret_pc", bus.redirect_pc_o, 32'h0000_0204);
    bus.mret_i = 1'b0;
    bus.mie_i = 1'b1;
    cycle();
    chk("t1_done_drop", 32'(bus.irq_done_o), 32'd0);

    // Lines 3 and 7 with MIE off, then lowest index first
    bus.mie_i = 1'b0;
    bus.irq_lines_i[3] = 1'b1;
    bus.irq_lines_i[7] = 1'b1;
    repeat (3) cycle();
    chk("t2_masked", 32'(bus.redirect_o), 32'd0);
    chk("t2_pend", 32'(bus.pending_o), 32'h0088);
    bus.mie_i = 1'b1;
    cycle();
    chk("t2_id3", 32'(bus.irq_id_o), 32'd3);
    cycle();
    bus.mie_i = 1'b0;
    bus.mret_i = 1'b1;
    cycle();
    bus.mret_i = 1'b0;
    bus.mie_i = 1'b1;
    cycle();
    cycle();
    chk("t2_id7", 32'(bus.irq_id_o), 32'd7);
    chk("t2_tgt7", bus.redirect_pc_o, 32'h0000_101C);
    cycle();
    bus.mie_i = 1'b0;
    bus.mret_i = 1'b1;
    cycle();
    bus.mret_i = 1'b0;
    cycle();
    bus.irq_lines_i = '0;

    // Exception beats pending interrupt; held strobe while fetch stalls
    bus.mie_i = 1'b1;
    bus.irq_lines_i[9] = 1'b1;
    cycle();
    bus.exc_req_i = 1'b1;
    bus.exc_id_i  = 5'd11;
    bus.mret_i    = 1'b1;
    bus.fetch_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t3_exc", 32'(bus.exc_taken_o), 32'd1);
      chk("t3_id", 32'(bus.irq_id_o), 32'd11);
      chk("t3_tgt", bus.redirect_pc_o, 32'h0000_1000);
    end
    bus.fetch_ready_i = 1'b1;
    bus.mret_i = 1'b0;
    bus.exc_req_i = 1'b0;
    bus.mie_i = 1'b0;
    cycle();
    chk("t3_drop", 32'(bus.redirect_o), 32'd0);
    bus.mret_i = 1'b1;
    cycle();
    bus.mret_i = 1'b0;
    bus.mie_i = 1'b1;
    cycle();
    cycle();
    chk("t3_id9", 32'(bus.irq_id_o), 32'd9);
    bus.irq_lines_i = '0;

    // Reset while a trap is stalled
    bus.fetch_ready_i = 1'b0;
    cycle();
    chk("t4_in_trap", 32'(bus.redirect_o), 32'd1);
    #1 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("t4_rst_redir", 32'(bus.redirect_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.fetch_ready_i = 1'b1;

    // Randomized traffic with the privilege block's MIE behaviour emulated
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) bus.irq_lines_i[$urandom_range(0, 15)] ^= 1'b1;
      bus.exc_req_i = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0: bus.exc_id_i = 5'd2;
        1: bus.exc_id_i = 5'd3;
        default: bus.exc_id_i = 5'd11;
      endcase
      bus.mret_i        = ($urandom_range(0, 6) == 0);
      bus.fetch_ready_i = ($urandom_range(0, 3) != 0);
      if (m_trap_commit) bus.mie_i = 1'b0;
      else if (m_ret_commit) bus.mie_i = 1'b1;
      else if ($urandom_range(0, 19) == 0) bus.mie_i = ~bus.mie_i;
      bus.mtvec_i  = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFE1 : 32'($urandom);
      bus.mepc_i   = 32'($urandom);
      bus.cur_pc_i = 32'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
